// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encoding and start-pattern helper for the LED sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE_UP   = 2'b00,
        MODE_CHASE_DOWN = 2'b01,
        MODE_BOUNCE     = 2'b10,
        MODE_BLINK      = 2'b11
    } led_mode_e;

    // Bit idx of the pattern loaded when a new mode takes effect on an n-LED strip.
    // Returned per bit so the caller can size the vector to its own NUM_LEDS.
    function automatic logic start_pattern(input logic [1:0] mode, input int n, input int idx);
        case (mode)
            MODE_CHASE_DOWN: return (idx == n - 1);
            MODE_BLINK:      return 1'b1;
            default:         return (idx == 0);
        endcase
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step-rate prescaler producing a one-cycle tick every TICK_DIV>>speed cycles
module led_prescaler #(
    parameter int TICK_DIV = 2500000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit_m1;

    // Terminal count for the selected rate; a >= compare lets a sudden speed-up
    // that strands cnt above the new limit tick at once instead of wrapping.
    always_comb begin
        limit_m1 = CNT_W'((TICK_DIV >> speed) - 1);
        tick     = en && (cnt >= limit_m1);
    end

    // Free-running counter, frozen while disabled, cleared on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern generator: chase up/down, bounce and blink on a prescaled tick
module led_sequencer #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 2500000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    output logic [NUM_LEDS-1:0] led,
    output logic                dir,
    output logic                step_pulse
);

    import led_seq_pkg::*;

    logic                tick;
    led_mode_e           mode_q;
    led_mode_e           mode_q_d;
    logic [NUM_LEDS-1:0] led_d;
    logic                dir_d;
    logic [NUM_LEDS-1:0] start_vec;
    logic [NUM_LEDS-1:0] rot_l;
    logic [NUM_LEDS-1:0] rot_r;
    logic [NUM_LEDS-1:0] shl;
    logic [NUM_LEDS-1:0] shr;

    led_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .speed (speed),
        .tick  (tick)
    );

    // Candidate next vectors; the rotate forms collapse to identity when NUM_LEDS is 1.
    always_comb begin
        start_vec = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            start_vec[i] = start_pattern(mode, NUM_LEDS, i);
        end
        rot_l = (led << 1) | (led >> (NUM_LEDS - 1));
        rot_r = (led >> 1) | (led << (NUM_LEDS - 1));
        shl   = led << 1;
        shr   = led >> 1;
    end

    // Next-state: a tick either reloads for a newly requested mode or advances the current one.
    always_comb begin
        mode_q_d = mode_q;
        led_d    = led;
        dir_d    = dir;
        if (tick) begin
            if (mode != mode_q) begin
                mode_q_d = led_mode_e'(mode);
                led_d    = start_vec;
                case (led_mode_e'(mode))
                    MODE_CHASE_UP:   dir_d = 1'b1;
                    MODE_CHASE_DOWN: dir_d = 1'b0;
                    MODE_BOUNCE:     dir_d = 1'b1;
                    default:         dir_d = dir;
                endcase
            end else begin
                case (mode_q)
                    MODE_CHASE_UP:   led_d = rot_l;
                    MODE_CHASE_DOWN: led_d = rot_r;
                    MODE_BOUNCE: begin
                        // A single LED has nowhere to bounce to, so it simply stays lit.
                        if (NUM_LEDS > 1) begin
                            if (dir) begin
                                if (led[NUM_LEDS-1]) begin
                                    led_d = shr;
                                    dir_d = 1'b0;
                                end else begin
                                    led_d = shl;
                                end
                            end else begin
                                if (led[0]) begin
                                    led_d = shl;
                                    dir_d = 1'b1;
                                end else begin
                                    led_d = shr;
                                end
                            end
                        end
                    end
                    MODE_BLINK:      led_d = ~led;
                    default:         led_d = led;
                endcase
            end
        end
    end

    // Output and mode registers; all three outputs move on the same edge after a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_CHASE_UP;
            led        <= NUM_LEDS'(1);
            dir        <= 1'b1;
            step_pulse <= 1'b0;
        end else begin
            mode_q     <= mode_q_d;
            led        <= led_d;
            dir        <= dir_d;
            step_pulse <= tick;
        end
    end

endmodule
